timer: RTL and testbench

- Parameterised enable-gated cycle counter with a reach-target flag.
- Counts clock edges on which `in` is high and raises `hit_target` once the accumulated count reaches `target`.
- Used as the timing primitive under higher-level sequencing FSMs, for example the 60 s gate.
- A wide instance serves synthesis; a 6-bit instance with target 60 serves simulation.

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer.sv | 44 ++++
 tb/tb_timer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and helpers for the enable-gated cycle timer.
package timer_pkg;

  // Counter width of the synthesis build.
  localparam int TIMER_WIDTH_DEFAULT = 26;

  // Counter width and target of the short build used in simulation.
  localparam int TIMER_WIDTH_SIM  = 6;
  localparam int TIMER_TARGET_SIM = 60;

  // True once an accumulated count has reached its terminal value.
  // Both operands are zero-extended to 32 bits, so widths 1..32 share one helper.
  function automatic logic count_reached(input logic [31:0] count, input logic [31:0] limit);
    return (count >= limit);
  endfunction

endpackage : timer_pkg

// File: rtl/timer.sv
// timer: counts rising clock edges with in=1 and flags when the count reaches target.
// The count saturates at target rather than wrapping, and pauses while in=0.
// hit_target is combinational from the count register and the live target input.
module timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active low
  input  logic             in,         // count enable
  input  logic [WIDTH-1:0] target,     // terminal count, unsigned
  output logic             hit_target
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             w_reached;

  // Reached flag is shared by the saturation test and the output, so an
  // all-ones count never increments and the counter cannot overflow.
  assign w_reached  = count_reached(32'(r_count), 32'(target));
  assign hit_target = w_reached;

  // Next count: advance only while enabled and still below target.
  always_comb begin
    w_count_next = r_count;
    if (!w_reached && in) begin
      w_count_next = r_count + WIDTH'(1);
    end else begin
      w_count_next = r_count;
    end
  end

  // Count register; asynchronous reset clears it regardless of clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

endmodule : timer

// File: tb/tb_timer.sv
// tb_timer: directed test of the 6-bit timer against an enabled-edge counting model.
module tb_timer;

  localparam int W = 6;

  logic         clk;
  logic         reset;
  logic         in;
  logic [W-1:0] target;
  logic         hit_target;

  int total;
  int bad;
  int model_count;
  bit chk_en;

  timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .target     (target),
    .hit_target (hit_target)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record one comparison, reporting it when it disagrees.
  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: number of enabled edges taken while still short of the target.
  always @(posedge clk) begin
    if (reset === 1'b1 && in === 1'b1 && model_count < int'(target)) begin
      model_count = model_count + 1;
    end
  end

  // Model: reset clears the accumulated count at once.
  always @(negedge reset) begin
    model_count = 0;
  end

  // Per-cycle comparison of the DUT against the model, shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("cyc_hit", int'(hit_target), (model_count >= int'(target)) ? 1 : 0);
      check("cyc_count", int'(dut.r_count), model_count);
    end
  end

  // Advance n full clock cycles; inputs change on falling edges only.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse reset low for one cycle, ending on a falling edge.
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    model_count = 0;
    chk_en      = 1'b0;
    reset       = 1'b0;
    in          = 1'b0;
    target      = 6'd60;
    step(2);
    check("reset_hit", int'(hit_target), 0);
    check("reset_count", int'(dut.r_count), 0);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Idle: no enabled edges, nothing moves.
    step(100);
    check("idle_hit", int'(hit_target), 0);
    check("idle_count", int'(dut.r_count), 0);

    // Continuous enable: flag rises exactly on the 60th enabled edge.
    in = 1'b1;
    step(59);
    check("run59_hit", int'(hit_target), 0);
    step(1);
    check("run60_hit", int'(hit_target), 1);
    check("run60_count", int'(dut.r_count), 60);
    step(40);
    check("sat_count", int'(dut.r_count), 60);

    // Enable removed: flag and count hold.
    in = 1'b0;
    step(100);
    check("hold_hit", int'(hit_target), 1);
    check("hold_count", int'(dut.r_count), 60);

    // Gap in enable: 30 on, 10 off, then 30 more -> hit at cycle 70.
    pulse_reset();
    in = 1'b1;
    step(30);
    in = 1'b0;
    step(10);
    check("gap_count", int'(dut.r_count), 30);
    in = 1'b1;
    step(29);
    check("gap69_hit", int'(hit_target), 0);
    step(1);
    check("gap70_hit", int'(hit_target), 1);

    // target=0: flag set during and out of reset, counter never moves.
    @(negedge clk);
    reset  = 1'b0;
    target = 6'd0;
    #2;
    check("t0_reset_hit", int'(hit_target), 1);
    @(negedge clk);
    reset = 1'b1;
    step(10);
    check("t0_hit", int'(hit_target), 1);
    check("t0_count", int'(dut.r_count), 0);

    // All-ones target: reached after 63 edges, no wrap afterwards.
    @(negedge clk);
    reset  = 1'b0;
    target = 6'd63;
    @(negedge clk);
    reset = 1'b1;
    step(62);
    check("t63_62_hit", int'(hit_target), 0);
    step(1);
    check("t63_hit", int'(hit_target), 1);
    check("t63_count", int'(dut.r_count), 63);
    step(5);
    check("t63_nowrap", int'(dut.r_count), 63);

    // Asynchronous reset between edges at count=25, then a full recount.
    @(negedge clk);
    reset  = 1'b0;
    target = 6'd60;
    @(negedge clk);
    reset = 1'b1;
    step(25);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", int'(dut.r_count), 0);
    check("async_hit", int'(hit_target), 0);
    @(negedge clk);
    reset = 1'b1;
    step(59);
    check("rerun59_hit", int'(hit_target), 0);
    step(1);
    check("rerun60_hit", int'(hit_target), 1);

    // Target lowered below count: flag at once, count holds; raised: resumes.
    pulse_reset();
    step(30);
    target = 6'd20;
    #1;
    check("lower_hit", int'(hit_target), 1);
    step(3);
    check("lower_count", int'(dut.r_count), 30);
    target = 6'd40;
    #1;
    check("raise_hit", int'(hit_target), 0);
    step(9);
    check("raise9_hit", int'(hit_target), 0);
    step(1);
    check("raise_hit2", int'(hit_target), 1);
    check("raise_count", int'(dut.r_count), 40);

    chk_en = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_timer
